// File: rtl/alu_btn_driver_if.sv
// rtl/alu_btn_driver_if.sv - command and result handshake bundle for alu_btn_driver
interface alu_btn_driver_if #(
    parameter int NB_DATA_IN    = 8,
    parameter int NB_OP_CODE_IN = 6,
    parameter int NB_DATA_OUT   = 10
);
    logic                     i_valid;
    logic                     o_ready;
    logic [NB_DATA_IN-1:0]    i_data_a;
    logic [NB_DATA_IN-1:0]    i_data_b;
    logic [NB_OP_CODE_IN-1:0] i_op_code;
    logic                     o_result_valid;
    logic                     i_result_ready;
    logic [NB_DATA_OUT-1:0]   o_result;

    modport master (
        output i_valid, i_data_a, i_data_b, i_op_code, i_result_ready,
        input  o_ready, o_result_valid, o_result
    );

    modport slave (
        input  i_valid, i_data_a, i_data_b, i_op_code, i_result_ready,
        output o_ready, o_result_valid, o_result
    );
endinterface

// File: rtl/alu_btn_driver.sv
// rtl/alu_btn_driver.sv - replays the A/B/opcode switch+button load sequence into top_alu
module alu_btn_driver #(
    parameter int NB_DATA_IN      = 8,
    parameter int NB_OP_CODE_IN   = 6,
    parameter int NB_INPUT_SELECT = 3,
    parameter int NB_DATA_OUT     = 10,
    parameter int SETUP_CYC       = 10,
    parameter int PRESS_CYC       = 10,
    parameter int RELEASE_CYC     = 10,
    parameter int RESULT_WAIT     = 2
) (
    input  logic                       clock,
    input  logic                       i_rst_n,
    alu_btn_driver_if.slave            cmd,
    output logic [NB_DATA_IN-1:0]      o_sw_data,
    output logic [NB_INPUT_SELECT-1:0] o_btn,
    input  logic [NB_DATA_OUT-1:0]     i_led
);
    localparam int MAX_SP  = (SETUP_CYC > PRESS_CYC) ? SETUP_CYC : PRESS_CYC;
    localparam int MAX_RW  = (RELEASE_CYC > RESULT_WAIT + 1) ? RELEASE_CYC : RESULT_WAIT + 1;
    localparam int MAX_CNT = (MAX_SP > MAX_RW) ? MAX_SP : MAX_RW;
    localparam int CW      = $clog2(MAX_CNT) + 1;

    localparam logic [CW-1:0] SETUP_LAST   = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_CYC - 1);
    localparam logic [CW-1:0] RELEASE_LAST = CW'(RELEASE_CYC - 1);
    // WAIT runs one extra cycle: the LED word is sampled on the edge that leaves it
    localparam logic [CW-1:0] WAIT_LAST    = CW'(RESULT_WAIT);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_PRESS, S_RELEASE, S_WAIT, S_RESP
    } state_t;

    state_t                     state, state_nxt;
    logic [CW-1:0]              cnt, cnt_nxt;
    logic [1:0]                 field, field_nxt;
    logic [NB_DATA_IN-1:0]      a_q, a_nxt, b_q, b_nxt;
    logic [NB_OP_CODE_IN-1:0]   op_q, op_nxt;
    logic [NB_DATA_IN-1:0]      sw_nxt;
    logic [NB_INPUT_SELECT-1:0] btn_nxt;
    logic [NB_DATA_OUT-1:0]     result_q, result_nxt;
    logic                       valid_q, valid_nxt;
    logic                       ready_q, ready_nxt;
    logic [NB_DATA_IN-1:0]      next_field_val;
    logic [NB_INPUT_SELECT-1:0] field_onehot;

    always_ff @(posedge clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            field     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            o_sw_data <= '0;
            o_btn     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            field     <= field_nxt;
            a_q       <= a_nxt;
            b_q       <= b_nxt;
            op_q      <= op_nxt;
            o_sw_data <= sw_nxt;
            o_btn     <= btn_nxt;
            result_q  <= result_nxt;
            valid_q   <= valid_nxt;
            ready_q   <= ready_nxt;
        end
    end

    always_comb begin
        next_field_val = (field == 2'd0) ? b_q : NB_DATA_IN'(op_q);
        field_onehot   = '0;
        case (field)
            2'd0:    field_onehot[0] = 1'b1;
            2'd1:    field_onehot[1] = 1'b1;
            default: field_onehot[2] = 1'b1;
        endcase
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        field_nxt  = field;
        a_nxt      = a_q;
        b_nxt      = b_q;
        op_nxt     = op_q;
        sw_nxt     = o_sw_data;
        btn_nxt    = o_btn;
        result_nxt = result_q;
        valid_nxt  = valid_q;
        case (state)
            S_IDLE: begin
                if (cmd.i_valid && ready_q) begin
                    a_nxt     = cmd.i_data_a;
                    b_nxt     = cmd.i_data_b;
                    op_nxt    = cmd.i_op_code;
                    field_nxt = 2'd0;
                    cnt_nxt   = '0;
                    sw_nxt    = cmd.i_data_a;
                    btn_nxt   = '0;
                    state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt == SETUP_LAST) begin
                    cnt_nxt   = '0;
                    btn_nxt   = field_onehot;
                    state_nxt = S_PRESS;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_PRESS: begin
                if (cnt == PRESS_LAST) begin
                    cnt_nxt   = '0;
                    btn_nxt   = '0;
                    state_nxt = S_RELEASE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                if (cnt == RELEASE_LAST) begin
                    cnt_nxt = '0;
                    if (field == 2'd2) begin
                        state_nxt = S_WAIT;
                    end else begin
                        field_nxt = field + 2'd1;
                        sw_nxt    = next_field_val;
                        state_nxt = S_SETUP;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt == WAIT_LAST) begin
                    cnt_nxt    = '0;
                    result_nxt = i_led;
                    valid_nxt  = 1'b1;
                    state_nxt  = S_RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_RESP: begin
                if (cmd.i_result_ready) begin
                    valid_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign ready_nxt          = (state_nxt == S_IDLE);
    assign cmd.o_ready        = ready_q;
    assign cmd.o_result_valid = valid_q;
    assign cmd.o_result       = result_q;
endmodule
